// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style responder: accepts a trigger, waits a burst delay, then
// drives an echo pulse whose width encodes the programmed distance.
module ultrasonic_echo_emulator #(
  parameter int unsigned TRIG_MIN_CYCLES    = 500,
  parameter int unsigned BURST_DELAY_CYCLES = 10_000,
  parameter int unsigned CYCLES_PER_UNIT    = 2_900,
  parameter int unsigned MAX_DIST           = 400,
  parameter int unsigned TIMEOUT_CYCLES     = 1_900_000,
  parameter int unsigned HOLDOFF_CYCLES     = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [15:0] distance,
  output logic        echo,
  output logic        busy,
  output logic        trig_err
);

  localparam logic [31:0] TRIG_MIN = 32'(TRIG_MIN_CYCLES);
  localparam logic [31:0] BURST_L  = 32'(BURST_DELAY_CYCLES - 1);
  localparam logic [31:0] UNIT_L   = 32'(CYCLES_PER_UNIT - 1);
  localparam logic [31:0] MAX_D    = 32'(MAX_DIST);
  localparam logic [31:0] TMO_L    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLD_L   = 32'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HIGH,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  state_t      state_q, state_d;
  logic        trig_m, trig_s, trig_p;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic [15:0] dist_q, dist_d;
  logic        tmo_q, tmo_d;
  logic        echo_d, err_d;
  logic        rise, fall;
  logic        unit_wrap, echo_done;
  logic [31:0] dist_last;

  assign rise      = trig_s & ~trig_p;
  assign fall      = ~trig_s & trig_p;
  assign dist_last = {16'd0, dist_q} - 32'd1;
  assign unit_wrap = (cnt_q == UNIT_L);
  // Timeout path is one flat counter; ranged path is unit x distance.
  assign echo_done = tmo_q ? (cnt_q == TMO_L)
                           : (unit_wrap && dcnt_q == dist_last);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_m   <= 1'b0;
      trig_s   <= 1'b0;
      trig_p   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      dist_q   <= '0;
      tmo_q    <= 1'b0;
      echo     <= 1'b0;
      trig_err <= 1'b0;
    end else begin
      trig_m   <= trig;
      trig_s   <= trig_m;
      trig_p   <= trig_s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      dist_q   <= dist_d;
      tmo_q    <= tmo_d;
      echo     <= echo_d;
      trig_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    dist_d  = dist_q;
    tmo_d   = tmo_q;
    echo_d  = echo;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = 32'd1;
          state_d = TRIG_HIGH;
        end
      end
      TRIG_HIGH: begin
        if (fall) begin
          cnt_d = '0;
          if (cnt_q >= TRIG_MIN) begin
            dist_d  = distance;
            tmo_d   = (distance == 16'd0) ||
                      ({16'd0, distance} > MAX_D);
            state_d = BURST;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (trig_s && cnt_q != 32'hFFFF_FFFF) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      BURST: begin
        if (cnt_q == BURST_L) begin
          cnt_d   = '0;
          dcnt_d  = '0;
          echo_d  = 1'b1;
          state_d = ECHO;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ECHO: begin
        if (echo_done) begin
          cnt_d   = '0;
          echo_d  = 1'b0;
          state_d = HOLDOFF;
        end else if (!tmo_q && unit_wrap) begin
          cnt_d  = '0;
          dcnt_d = dcnt_q + 32'd1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_L) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        echo_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Scoreboard bench for ultrasonic_echo_emulator: expected echo rise
// cycles and widths are queued at stimulus time and checked on output.
module tb_ultrasonic_echo_emulator;

  localparam int unsigned LAT = 3 + 20;

  typedef struct {
    int unsigned w;
    int unsigned rise;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        trig;
  logic [15:0] distance;
  logic        echo;
  logic        busy;
  logic        trig_err;

  int unsigned cyc;
  int unsigned n_chk;
  int unsigned n_err;
  int unsigned n_echo;
  int unsigned n_errp;
  bit          abort;
  exp_t        sb[$];

  ultrasonic_echo_emulator #(
    .TRIG_MIN_CYCLES   (10),
    .BURST_DELAY_CYCLES(20),
    .CYCLES_PER_UNIT   (4),
    .MAX_DIST          (100),
    .TIMEOUT_CYCLES    (500),
    .HOLDOFF_CYCLES    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .distance(distance),
    .echo    (echo),
    .busy    (busy),
    .trig_err(trig_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops one expectation per echo pulse.
  initial begin
    exp_t        cur;
    bit          have, hold_pend;
    bit          echo_p, busy_p, err_p;
    int unsigned rise_c, fall_c;
    have = 0;
    hold_pend = 0;
    echo_p = 0;
    busy_p = 0;
    err_p = 0;
    rise_c = 0;
    fall_c = 0;
    forever begin
      @(negedge clk);
      if (echo && !echo_p) begin
        n_echo++;
        rise_c = cyc;
        if (sb.size() == 0) begin
          chk("unexpected echo", 1, 0);
          have = 0;
        end else begin
          cur = sb.pop_front();
          have = 1;
          chk("echo rise", cyc, cur.rise);
        end
      end
      if (!echo && echo_p) begin
        if (abort) begin
          abort = 0;
          hold_pend = 0;
        end else begin
          if (have) chk("echo width", cyc - rise_c, cur.w);
          fall_c = cyc;
          hold_pend = 1;
        end
        have = 0;
      end
      if (!busy && busy_p && hold_pend) begin
        chk("holdoff", cyc - fall_c, 8);
        hold_pend = 0;
      end
      if (trig_err && !err_p) n_errp++;
      echo_p = echo;
      busy_p = busy;
      err_p  = trig_err;
    end
  end

  task automatic pulse(input int n, input logic [15:0] d,
                       input bit acc, input int unsigned w);
    distance = d;
    @(posedge clk);
    #1 trig = 1'b1;
    repeat (n) @(posedge clk);
    #1 trig = 1'b0;
    if (acc) sb.push_back('{w: w, rise: cyc + LAT});
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_echo(input string tag);
    int k = 0;
    while (!echo && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, echo, 1);
  endtask

  task automatic short_pulse(input int n, input string tag);
    bit seen = 0;
    pulse(n, 16'd25, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (trig_err) begin
        seen = 1;
        chk({tag, " busy"}, busy, 0);
        @(posedge clk);
        #1;
        chk({tag, " width"}, trig_err, 0);
        break;
      end
    end
    chk({tag, " seen"}, seen, 1);
    chk({tag, " busy after"}, busy, 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    n_echo = 0;
    n_errp = 0;
    abort = 0;
    rst = 1'b1;
    trig = 1'b0;
    distance = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset echo", echo, 0);
    chk("reset busy", busy, 0);
    chk("reset err", trig_err, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    pulse(12, 16'd25, 1, 100);
    wait_idle("idle d25");

    short_pulse(5, "short5");
    short_pulse(9, "short9");

    pulse(10, 16'd1, 1, 4);
    wait_idle("idle min trig");
    pulse(12, 16'd0, 1, 500);
    wait_idle("idle d0");
    pulse(12, 16'd101, 1, 500);
    wait_idle("idle d101");
    pulse(12, 16'd100, 1, 400);
    wait_idle("idle d100");

    pulse(12, 16'd25, 1, 100);
    repeat (10) @(posedge clk);
    #1 distance = 16'd50;
    wait_echo("echo start ign");
    repeat (30) @(posedge clk);
    pulse(15, 16'd50, 0, 0);
    wait_idle("idle ignore");
    repeat (40) @(posedge clk);
    #1 chk("no second echo busy", busy, 0);

    pulse(12, 16'd25, 1, 100);
    wait_echo("echo start rst");
    repeat (10) @(posedge clk);
    #3 abort = 1;
    rst = 1'b1;
    #1;
    chk("abort echo", echo, 0);
    chk("abort busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("sb after abort", sb.size(), 0);
    repeat (3) @(posedge clk);
    pulse(12, 16'd3, 1, 12);
    wait_idle("idle d3");

    pulse(12, 16'd25, 1, 100);
    wait_echo("echo start hold");
    trig = 1'b1;
    wait_idle("idle held");
    repeat (10) @(posedge clk);
    #1 trig = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("held no restart", busy, 0);
    pulse(12, 16'd25, 1, 100);
    wait_idle("idle after held");

    repeat (5) @(posedge clk);
    chk("sb empty", sb.size(), 0);
    chk("echo count", n_echo, 10);
    chk("err pulses", n_errp, 2);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ultrasonic_echo_emulator.md
Name: ultrasonic_echo_emulator

Overview:
- Synthesizable model of an HC-SR04-style ranging sensor: the responder end of the trigger/echo interface driven by the ultrasonic control block.
- Accepts a trigger pulse, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmed distance.
- Used for hardware-in-loop bring-up of the ranging path on the j1 SoC without a physical sensor; sits between a distance register and the controller's signal input.

Parameters:
- TRIG_MIN_CYCLES, 500, minimum synchronized trigger high time (10 us at 50 MHz); shorter pulses are rejected.
- BURST_DELAY_CYCLES, 10_000, cycles from accepted trigger fall to echo rise (emulated 8-cycle 40 kHz burst).
- CYCLES_PER_UNIT, 2_900, echo cycles per distance unit (58 us/cm at 50 MHz); must be ≥1.
- MAX_DIST, 400, largest valid distance in units.
- TIMEOUT_CYCLES, 1_900_000, echo width used for no-target or out-of-range (38 ms).
- HOLDOFF_CYCLES, 500, dead time after echo fall before a new trigger is accepted.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- trig, input, 1, trigger from controller (asynchronous to clk).
- distance, input, 16, programmed target distance in units.
- echo, output, 1, echo pulse to controller.
- busy, output, 1, high in any state other than IDLE.
- trig_err, output, 1, one-cycle pulse when a trigger is rejected as too short.

Behaviour:
- Reset: async on rst high; state=IDLE; echo=0, busy=0, trig_err=0; synchronizer flops, counters and latched distance cleared.
- trig passes a 2-flop synchronizer to give trig_s; edges are detected on trig_s against its previous registered value.
- States: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF.
- IDLE: trig_s rising edge goes to TRIG_HIGH with the high counter set to 1.
- TRIG_HIGH: the counter increments each cycle trig_s=1.
  - On trig_s falling edge with count ≥ TRIG_MIN_CYCLES: latch distance and go to BURST.
  - On falling edge with count < TRIG_MIN_CYCLES: pulse trig_err for 1 cycle and return to IDLE.
  - A trigger held high indefinitely stays in TRIG_HIGH; the counter saturates at 32'hFFFF_FFFF.
- BURST: echo rises on the edge exactly BURST_DELAY_CYCLES cycles after the edge on which the accepted fall was detected; the state then moves to ECHO.
- ECHO: echo high for exactly W cycles, then echo=0 and the state moves to HOLDOFF.
  - W = latched_distance × CYCLES_PER_UNIT when 1 ≤ latched_distance ≤ MAX_DIST.
  - Otherwise W = TIMEOUT_CYCLES (distance 0 or > MAX_DIST).
  - W is generated with an inner unit counter (0..CYCLES_PER_UNIT-1) and an outer distance counter, with no multiplier; the timeout path uses a single 32-bit counter.
- HOLDOFF: wait HOLDOFF_CYCLES cycles, then go to IDLE.
  - A trigger that is already high on entry to IDLE is not accepted; a fresh rising edge is required.
- Trigger activity in BURST, ECHO or HOLDOFF is ignored: no error, no restart.
- Changes on distance after the latch point do not affect the measurement in progress.
- busy=1 from entry to TRIG_HIGH through the last HOLDOFF cycle.
- All counters are 32 bits unsigned. Counter wrap is impossible within the parameter ranges, apart from the saturating TRIG_HIGH counter.
- Reset asserted mid-measurement aborts immediately: echo drops to 0 asynchronously and the next measurement needs a fresh trigger.

Test Plan:
- Bench parameters: TRIG_MIN=10, BURST=20, CPU=4, MAX_DIST=100, TIMEOUT=500, HOLDOFF=8.
- trig high 12 cycles, distance=25 -> echo rises 20 cycles after the detected fall, stays high exactly 100 cycles; busy falls 8 cycles after echo falls; trig_err never pulses.
- trig high 5 cycles -> trig_err pulses 1 cycle; echo stays 0; busy returns to 0 on the next cycle.
- distance=0, then distance=101, each with a valid trigger -> echo width exactly 500 cycles in both cases; distance=100 -> echo width exactly 400 cycles.
- Second trig pulse of 15 cycles issued mid-ECHO; distance changed 25→50 during BURST -> first echo is unaffected at 100 cycles, there is no second echo, and trig_err stays 0.
- rst pulsed mid-ECHO -> echo=0 and busy=0 immediately; a following valid trigger with distance=3 gives a 12-cycle echo.
- trig held high through the end of HOLDOFF, then released -> no measurement starts; the next full 12-cycle pulse produces a normal echo.
